data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder_pkg.sv | 24 ++
 rtl/data_mem_responder_if.sv | 38 +++
 rtl/data_mem_responder_sbuf_fifo.sv | 81 ++++++++
 rtl/data_mem_responder.sv | 138 +++++++++++++
 tb/tb_data_mem_responder.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data memory responder: store-buffer entry and controller state.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Optional feature macro used elsewhere in the bundle: DMEM_RANGE_CHK_EN.
// The entry fields are sized for the widest supported configuration
// (word index up to 32 bits, data below 64 bits). Narrower instances
// zero-extend on the way in and truncate on the way out.
package data_mem_responder_pkg;

  localparam int SB_IDX_MAX_W  = 32;
  localparam int SB_DATA_MAX_W = 64;

  typedef struct packed {
    logic [SB_IDX_MAX_W-1:0]  index;
    logic [SB_DATA_MAX_W-1:0] data;
  } sb_entry_t;

  typedef enum logic [1:0] {
    SB_EMPTY   = 2'd0,
    SB_PARTIAL = 2'd1,
    SB_FULL    = 2'd2
  } sb_state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Processor memory-stage bus for the data memory responder.
// Latency: reads are combinational, writes are posted into the store buffer.
// Backpressure: none; every request is accepted in the cycle it is presented.
// Signals: MRE/MWE requests, addressData byte address, storeData write data,
// loadedData read data, sb_count buffer occupancy, err (only with DMEM_RANGE_CHK_EN).
interface data_mem_responder_if #(
  parameter int mbus = 32,
  parameter int SBUF = 4
);
  localparam int CNT_W = $clog2(SBUF) + 1;

  logic             MRE;
  logic             MWE;
  logic [mbus-1:0]  addressData;
  logic [mbus-1:0]  storeData;
  logic [mbus-1:0]  loadedData;
  logic [CNT_W-1:0] sb_count;
`ifdef DMEM_RANGE_CHK_EN
  logic             err;
`endif

  modport master (
    output MRE, MWE, addressData, storeData,
    input  loadedData, sb_count
`ifdef DMEM_RANGE_CHK_EN
    , input err
`endif
  );

  modport slave (
    input  MRE, MWE, addressData, storeData,
    output loadedData, sb_count
`ifdef DMEM_RANGE_CHK_EN
    , output err
`endif
  );

endinterface

// File: rtl/data_mem_responder_sbuf_fifo.sv
// Store buffer: circular FIFO of {index, data} entries with parallel index match.
// Latency: push/pop take effect at the edge; match/hit outputs are combinational.
// Backpressure: none; the controller never pops when empty or pushes past full.
// Ports: push/push_entry enqueue at tail, pop retires head_entry, count is occupancy,
// query_index is compared against every live entry (match), hit/hit_data give the youngest.
module sbuf_fifo
  import data_mem_responder_pkg::*;
#(
  parameter int SBUF  = 4,
  parameter int IDX_W = 8,
  parameter int CNT_W = $clog2(SBUF) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  sb_entry_t                push_entry,
  input  logic                     pop,
  output sb_entry_t                head_entry,
  output logic [CNT_W-1:0]         count,
  input  logic [IDX_W-1:0]         query_index,
  output logic [SBUF-1:0]          match,
  output logic                     hit,
  output logic [SB_DATA_MAX_W-1:0] hit_data
);
  localparam int PTR_W = $clog2(SBUF);

  sb_entry_t        slots [SBUF];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // Pointers are exactly PTR_W bits wide, so increments wrap modulo SBUF.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset: the count decides which slots are live.
  always_ff @(posedge clk) begin
    if (!rst && push) slots[tail] <= push_entry;
  end

  assign head_entry = slots[head];

  // A slot is live when its age (distance from head) is below the count.
  always_comb begin
    match = '0;
    for (int i = 0; i < SBUF; i++) begin
      logic [PTR_W-1:0] age;
      age = PTR_W'(i) - head;
      if (({1'b0, age} < count) &&
          (slots[i].index == SB_IDX_MAX_W'(query_index)))
        match[i] = 1'b1;
    end
  end

  // Walk from oldest to youngest so the last matching slot wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int k = 0; k < SBUF; k++) begin
      logic [PTR_W-1:0] slot;
      slot = head + PTR_W'(k);
      if (match[slot]) begin
        hit      = 1'b1;
        hit_data = slots[slot].data;
      end
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data memory for a non-stalling pipeline: combinational reads with store-buffer
// forwarding, writes posted to a FIFO that drains into a single-port array when idle.
// Latency: read data in the request cycle; write visible to reads from the next cycle.
// Backpressure: none; a write into a full buffer forces the head to drain at the same edge.
// Ports: clk, rst (sync, active high), bus (slave side of data_mem_responder_if).
// Optional: define DMEM_RANGE_CHK_EN for the sticky out-of-range/misaligned err flag.
// Supports mbus below 64 and DEPTH index widths up to 32 bits.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int mbus  = 32,
  parameter int DEPTH = 256,
  parameter int SBUF  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  data_mem_responder_if.slave  bus
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(SBUF) + 1;

  logic [mbus-1:0]          mem [DEPTH];
  logic [IDX_W-1:0]         widx;
  logic                     addr_bad;
  logic                     rd_en;
  logic                     wr_en;
  logic                     push;
  logic                     pop;
  sb_entry_t                push_entry;
  sb_entry_t                head_entry;
  logic [CNT_W-1:0]         count;
  logic [SBUF-1:0]          match;
  logic                     hit;
  logic [SB_DATA_MAX_W-1:0] hit_data;
  sb_state_e                state_q;
  sb_state_e                state_d;

  assign widx = bus.addressData[IDX_W+1:2];

`ifdef DMEM_RANGE_CHK_EN
  localparam logic [mbus:0] ADDR_LIMIT = (mbus+1)'(4 * DEPTH);
  logic err_q;

  assign addr_bad = ({1'b0, bus.addressData} >= ADDR_LIMIT) ||
                    (bus.addressData[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (rst)
      err_q <= 1'b0;
    else if ((bus.MRE || bus.MWE) && addr_bad)
      err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  // Without the checker the address is simply truncated to the index bits.
  assign addr_bad = 1'b0;
`endif

  assign rd_en = bus.MRE && !rst && !addr_bad;
  assign wr_en = bus.MWE && !rst && !addr_bad;

  assign push_entry.index = SB_IDX_MAX_W'(widx);
  assign push_entry.data  = SB_DATA_MAX_W'(bus.storeData);

  always_ff @(posedge clk) begin
    if (rst) state_q <= SB_EMPTY;
    else     state_q <= state_d;
  end

  // Drain policy: use the array port whenever the processor is not reading,
  // and steal it during a read only when a write would otherwise overflow.
  always_comb begin
    state_d = state_q;
    push    = wr_en;
    pop     = 1'b0;
    case (state_q)
      SB_EMPTY: begin
        if (push) state_d = SB_PARTIAL;
      end
      SB_PARTIAL: begin
        pop = !bus.MRE;
        if (push && !pop && (count == CNT_W'(SBUF - 1)))
          state_d = SB_FULL;
        else if (pop && !push && (count == CNT_W'(1)))
          state_d = SB_EMPTY;
      end
      SB_FULL: begin
        pop = !bus.MRE || push;
        if (pop && !push) state_d = SB_PARTIAL;
      end
      default: state_d = SB_EMPTY;
    endcase
  end

  sbuf_fifo #(
    .SBUF  (SBUF),
    .IDX_W (IDX_W),
    .CNT_W (CNT_W)
  ) u_sbuf (
    .clk         (clk),
    .rst         (rst),
    .push        (push),
    .push_entry  (push_entry),
    .pop         (pop),
    .head_entry  (head_entry),
    .count       (count),
    .query_index (widx),
    .match       (match),
    .hit         (hit),
    .hit_data    (hit_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (pop) begin
      mem[head_entry.index[IDX_W-1:0]] <= head_entry.data[mbus-1:0];
    end
  end

  // The buffer is read before this cycle's enqueue lands, so a same-cycle
  // read/write returns the old value.
  always_comb begin
    bus.loadedData = '0;
    if (rd_en)
      bus.loadedData = hit ? hit_data[mbus-1:0] : mem[widx];
  end

  assign bus.sb_count = count;

  logic unused_bits;
  assign unused_bits = ^{bus.addressData[mbus-1:IDX_W+2], bus.addressData[1:0],
                         head_entry.index[SB_IDX_MAX_W-1:IDX_W],
                         head_entry.data[SB_DATA_MAX_W-1:mbus],
                         hit_data[SB_DATA_MAX_W-1:mbus], match};

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if #(.mbus(32), .SBUF(4)) ifc ();

  data_mem_responder #(.mbus(32), .DEPTH(256), .SBUF(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct {
    logic        mre;
    logic        mwe;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_cnt;
  } vec_t;

  vec_t vt[$];
  int total = 0;
  int bad   = 0;

  function automatic vec_t mk(logic mre, logic mwe, logic [31:0] addr,
                              logic [31:0] wdata, logic [31:0] exp_data, int exp_cnt);
    vec_t v;
    v.mre = mre; v.mwe = mwe; v.addr = addr; v.wdata = wdata;
    v.exp_data = exp_data; v.exp_cnt = exp_cnt;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(logic mre, logic mwe, logic [31:0] addr, logic [31:0] wdata);
    ifc.MRE         = mre;
    ifc.MWE         = mwe;
    ifc.addressData = addr;
    ifc.storeData   = wdata;
  endtask

  initial begin
    logic [31:0] exp_tail0;
    logic [31:0] exp_tail1;
`ifdef DMEM_RANGE_CHK_EN
    exp_tail0 = 32'h0;
    exp_tail1 = 32'h0;
`else
    exp_tail0 = 32'h55;
    exp_tail1 = 32'h55;
`endif
    // basic forwarding and drain
    vt.push_back(mk(0, 0, 32'h00, 32'h0,        32'h0,        0));
    vt.push_back(mk(0, 1, 32'h10, 32'hDEADBEEF, 32'h0,        0));
    vt.push_back(mk(1, 0, 32'h10, 32'h0,        32'hDEADBEEF, 1));
    vt.push_back(mk(0, 0, 32'h10, 32'h0,        32'h0,        1));
    vt.push_back(mk(1, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0));
    // youngest match wins; same-cycle read sees older entry
    vt.push_back(mk(0, 1, 32'h20, 32'h1,        32'h0,        0));
    vt.push_back(mk(1, 1, 32'h20, 32'h2,        32'h1,        1));
    vt.push_back(mk(1, 0, 32'h20, 32'h0,        32'h2,        2));
    vt.push_back(mk(0, 0, 32'h20, 32'h0,        32'h0,        2));
    vt.push_back(mk(0, 0, 32'h20, 32'h0,        32'h0,        1));
    vt.push_back(mk(1, 0, 32'h20, 32'h0,        32'h2,        0));
    // five writes with MRE held: saturate at 4 with forced drain
    vt.push_back(mk(1, 1, 32'h00, 32'hA0,       32'h0,        0));
    vt.push_back(mk(1, 1, 32'h04, 32'hA1,       32'h0,        1));
    vt.push_back(mk(1, 1, 32'h08, 32'hA2,       32'h0,        2));
    vt.push_back(mk(1, 1, 32'h0C, 32'hA3,       32'h0,        3));
    vt.push_back(mk(1, 1, 32'h10, 32'hA4,       32'hDEADBEEF, 4));
    vt.push_back(mk(1, 0, 32'h00, 32'h0,        32'hA0,       4));
    vt.push_back(mk(0, 0, 32'h00, 32'h0,        32'h0,        4));
    vt.push_back(mk(0, 0, 32'h00, 32'h0,        32'h0,        3));
    vt.push_back(mk(0, 0, 32'h00, 32'h0,        32'h0,        2));
    vt.push_back(mk(0, 0, 32'h00, 32'h0,        32'h0,        1));
    vt.push_back(mk(1, 0, 32'h00, 32'h0,        32'hA0,       0));
    vt.push_back(mk(1, 0, 32'h04, 32'h0,        32'hA1,       0));
    vt.push_back(mk(1, 0, 32'h08, 32'h0,        32'hA2,       0));
    vt.push_back(mk(1, 0, 32'h0C, 32'h0,        32'hA3,       0));
    vt.push_back(mk(1, 0, 32'h10, 32'h0,        32'hA4,       0));
    // same-cycle read and write returns the pre-write value
    vt.push_back(mk(1, 1, 32'h40, 32'h55,       32'h0,        0));
    vt.push_back(mk(1, 0, 32'h40, 32'h0,        32'h55,       1));
    vt.push_back(mk(0, 0, 32'h40, 32'h0,        32'h0,        1));
    // address truncation (or rejection when range checking is built in)
    vt.push_back(mk(1, 0, 32'h440, 32'h0,       exp_tail0,    0));
    vt.push_back(mk(1, 0, 32'h42,  32'h0,       exp_tail1,    0));

    drive(0, 0, 32'h0, 32'h0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < vt.size(); i++) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(vt[i].mre, vt[i].mwe, vt[i].addr, vt[i].wdata);
      @(negedge clk);
      check($sformatf("row%0d data", i), ifc.loadedData, vt[i].exp_data);
      check($sformatf("row%0d cnt", i), 32'(ifc.sb_count), 32'(vt[i].exp_cnt));
    end

    // reset with three buffered entries discards them and zeroes the array
    @(posedge clk); #1 drive(1, 1, 32'h80, 32'hB0);
    @(posedge clk); #1 drive(1, 1, 32'h84, 32'hB1);
    @(posedge clk); #1 drive(1, 1, 32'h88, 32'hB2);
    @(posedge clk); #1 drive(0, 0, 32'h80, 32'h0);
    @(negedge clk);
    check("pre_rst cnt", 32'(ifc.sb_count), 32'd3);
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    check("in_rst data", ifc.loadedData, 32'h0);
    @(posedge clk); #1 rst = 1'b0; drive(1, 0, 32'h80, 32'h0);
    @(negedge clk);
    check("post_rst cnt", 32'(ifc.sb_count), 32'd0);
    check("post_rst 0x80", ifc.loadedData, 32'h0);
    @(posedge clk); #1 drive(1, 0, 32'h84, 32'h0);
    @(negedge clk);
    check("post_rst 0x84", ifc.loadedData, 32'h0);
    @(posedge clk); #1 drive(1, 0, 32'h88, 32'h0);
    @(negedge clk);
    check("post_rst 0x88", ifc.loadedData, 32'h0);
    @(posedge clk); #1 drive(1, 0, 32'h10, 32'h0);
    @(negedge clk);
    check("post_rst array 0x10", ifc.loadedData, 32'h0);

`ifdef DMEM_RANGE_CHK_EN
    @(posedge clk); #1 rst = 1'b1; drive(0, 0, 32'h0, 32'h0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("err after rst", 32'(ifc.err), 32'd0);
    @(posedge clk); #1 drive(1, 0, 32'h400, 32'h0);
    @(negedge clk);
    check("oor read data", ifc.loadedData, 32'h0);
    @(posedge clk); #1 drive(0, 1, 32'h0, 32'h77);
    @(negedge clk);
    check("err set", 32'(ifc.err), 32'd1);
    @(posedge clk); #1 drive(0, 0, 32'h0, 32'h0);
    @(negedge clk);
    check("err sticky", 32'(ifc.err), 32'd1);
    check("valid write buffered", 32'(ifc.sb_count), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("err cleared", 32'(ifc.err), 32'd0);
`endif

    @(posedge clk); #1 drive(0, 0, 32'h0, 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
